inst_fetch_unit: RTL and testbench

Instruction-fetch initiator. It drives the request/address side of the instruction-memory interface and consumes the returned instruction and dataOk. It sequentially fetches 32-bit instructions into a small {pc, inst} prefetch FIFO that feeds decode, and handles branch/exception redirects, including killing a fetch already in flight. It sits between the instruction ROM/memory responder and the decode stage.

---
 rtl/inst_fetch_unit_if.sv | 24 ++
 rtl/inst_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory bus and decode-side handshake of the
// fetch unit. master = fetch unit, slave = memory responder / decode side.
interface inst_fetch_unit_if;
    logic        request_o;
    logic [31:0] instAddr_o;
    logic [31:0] inst_i;
    logic        dataOk_i;
    logic        redirect_i;
    logic [31:0] redirectPc_i;
    logic        instValid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        instReady_i;

    modport master (
        output request_o, instAddr_o, instValid_o, inst_o, pc_o,
        input  inst_i, dataOk_i, redirect_i, redirectPc_i, instReady_i
    );

    modport slave (
        input  request_o, instAddr_o, instValid_o, inst_o, pc_o,
        output inst_i, dataOk_i, redirect_i, redirectPc_i, instReady_i
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetcher feeding a {pc, inst}
// prefetch FIFO. Handles redirects, including killing an in-flight fetch
// (KILL waits for the orphaned response, then restarts at the held target).
// Optional macro FETCH_BYPASS_EN: a transfer landing on an empty FIFO is
// presented to decode combinationally in the same cycle.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

    state_t        state, state_nxt;
    logic [31:0]   req_addr, pend_pc, redir_pc;
    logic [31:0]   mem_pc   [FIFO_DEPTH];
    logic [31:0]   mem_inst [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] count, count_nxt, remain;
    logic          head_vld;
    logic [31:0]   head_pc, head_inst;
    logic          flush, xfer_ok, push, pop, bypass_take;

    assign redir_pc = bus.redirectPc_i & ~32'h3;
    assign flush    = bus.redirect_i;
    // A completed transfer that is not being discarded by a redirect
    assign xfer_ok  = (state == REQ) && bus.dataOk_i && !flush;

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = xfer_ok && !head_vld;
    assign bypass_take = bypass_hit && bus.instReady_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign push      = xfer_ok && !bypass_take;
    assign pop       = head_vld && bus.instReady_i && !flush;
    assign remain    = count - CW'(pop);
    assign count_nxt = flush ? '0 : remain + CW'(push);
    assign rd_nxt    = flush ? '0 : rd_ptr + PW'(pop);
    assign wr_nxt    = flush ? '0 : wr_ptr + PW'(push);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: request only drops at a transfer boundary
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!flush && count_nxt < DEPTH_C) state_nxt = REQ;
            REQ: begin
                if (bus.dataOk_i && !flush && count_nxt == DEPTH_C) state_nxt = IDLE;
                else if (!bus.dataOk_i && flush)                     state_nxt = KILL;
            end
            KILL: if (bus.dataOk_i) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: registered head, optionally overridden by the bypass path
    always_comb begin
        bus.request_o   = (state != IDLE);
        bus.instAddr_o  = req_addr;
        bus.instValid_o = head_vld;
        bus.inst_o      = head_inst;
        bus.pc_o        = head_pc;
`ifdef FETCH_BYPASS_EN
        if (bypass_hit) begin
            bus.instValid_o = 1'b1;
            bus.inst_o      = bus.inst_i;
            bus.pc_o        = req_addr;
        end
`endif
    end

    // Fetch address and pending redirect target
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr <= RESET_PC;
            pend_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: if (flush) req_addr <= redir_pc;
                REQ: begin
                    if (bus.dataOk_i) req_addr <= flush ? redir_pc : req_addr + 32'd4;
                    else if (flush)   pend_pc  <= redir_pc;
                end
                KILL: begin
                    if (bus.dataOk_i) req_addr <= flush ? redir_pc : pend_pc;
                    else if (flush)   pend_pc  <= redir_pc;
                end
                default: ;
            endcase
        end
    end

    // FIFO storage (no reset needed; only read once written)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= req_addr;
            mem_inst[wr_ptr] <= bus.inst_i;
        end
    end

    // FIFO pointers and registered head; head holds its value when empty
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_vld  <= 1'b0;
            head_pc   <= '0;
            head_inst <= '0;
        end else begin
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_nxt;
            count    <= count_nxt;
            head_vld <= (count_nxt != '0);
            if (!flush) begin
                if (remain != '0) begin
                    head_pc   <= mem_pc[rd_nxt];
                    head_inst <= mem_inst[rd_nxt];
                end else if (push) begin
                    head_pc   <= req_addr;
                    head_inst <= bus.inst_i;
                end
`ifdef FETCH_BYPASS_EN
                else if (bypass_take) begin
                    head_pc   <= req_addr;
                    head_inst <= bus.inst_i;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_inst_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 4;

    logic clk = 1'b0;
    logic reset;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int ws      = 0;
    int wcnt    = 0;
    bit cmp_en  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: queue of fetched entries, a busy flag for an open
    // transfer, and a kill flag meaning the open transfer's data is dropped.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    bit          m_busy, m_kill, m_done;
    logic [31:0] m_addr, m_pend, m_pc, m_inst, m_tgt;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_busy = 0; m_kill = 0;
            m_addr = RESET_PC; m_pend = 0; m_pc = 0; m_inst = 0;
        end else begin
            m_tgt  = {bus.redirectPc_i[31:2], 2'b00};
            m_done = m_busy && bus.dataOk_i;
            if (bus.redirect_i)                        mq.delete();
            else if (mq.size() > 0 && bus.instReady_i) void'(mq.pop_front());
            if (!m_busy) begin
                if (bus.redirect_i)        m_addr = m_tgt;
                else if (mq.size() < DEPTH) m_busy = 1;
            end else if (m_kill) begin
                if (m_done) begin
                    m_kill = 0;
                    m_addr = bus.redirect_i ? m_tgt : m_pend;
                end else if (bus.redirect_i) m_pend = m_tgt;
            end else begin
                if (m_done && !bus.redirect_i) begin
                    mq.push_back('{pc: m_addr, inst: bus.inst_i});
                    m_addr = m_addr + 32'd4;
                    if (mq.size() == DEPTH) m_busy = 0;
                end else if (m_done) m_addr = m_tgt;
                else if (bus.redirect_i) begin
                    m_kill = 1;
                    m_pend = m_tgt;
                end
            end
            if (mq.size() > 0) begin
                m_pc   = mq[0].pc;
                m_inst = mq[0].inst;
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("m_request", 32'(bus.request_o), 32'(m_busy));
            chk("m_addr", bus.instAddr_o, m_addr);
            chk("m_valid", 32'(bus.instValid_o), 32'(mq.size() > 0));
            chk("m_pc", bus.pc_o, m_pc);
            chk("m_inst", bus.inst_o, m_inst);
        end
    end

    // Memory responder with ws wait states per transfer
    initial begin
        bus.dataOk_i = 1'b0;
        bus.inst_i   = '0;
        forever begin
            @(negedge clk);
            if (reset || !bus.request_o) begin
                wcnt = 0;
                bus.dataOk_i = 1'b0;
            end else begin
                if (bus.dataOk_i) wcnt = 0;
                bus.dataOk_i = (wcnt >= ws);
                if (!bus.dataOk_i) wcnt++;
            end
            bus.inst_i = mem_word(bus.instAddr_o);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        bus.redirect_i   = 1'b1;
        bus.redirectPc_i = pc;
        @(negedge clk);
        bus.redirect_i   = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.redirect_i   = 1'b0;
        bus.redirectPc_i = '0;
        bus.instReady_i  = 1'b1;
        @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("rst_request", 32'(bus.request_o), 32'h0);
        chk("rst_addr", bus.instAddr_o, RESET_PC);
        chk("rst_valid", 32'(bus.instValid_o), 32'h0);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);

        // Zero-wait streaming
        reset = 1'b0;
        @(negedge clk);
        chk("s1_request", 32'(bus.request_o), 32'h1);
        chk("s1_addr0", bus.instAddr_o, 32'h0);
        chk("s1_valid0", 32'(bus.instValid_o), 32'h0);
        @(negedge clk);
        chk("s1_addr4", bus.instAddr_o, 32'h4);
        chk("s1_valid1", 32'(bus.instValid_o), 32'h1);
        chk("s1_pc0", bus.pc_o, 32'h0);
        chk("s1_inst0", bus.inst_o, 32'h5A5A_0F0F);
        repeat (3) @(negedge clk);
        chk("s1_addr10", bus.instAddr_o, 32'h10);
        chk("s1_pcC", bus.pc_o, 32'hC);

        // Decode stalled: FIFO fills to 4 then request drops
        bus.instReady_i = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        chk("s2_request", 32'(bus.request_o), 32'h0);
        chk("s2_addr", bus.instAddr_o, 32'h10);
        chk("s2_valid", 32'(bus.instValid_o), 32'h1);
        chk("s2_pc", bus.pc_o, 32'h0);
        bus.instReady_i = 1'b1;
        @(negedge clk);
        chk("s2_resume_req", 32'(bus.request_o), 32'h1);
        chk("s2_resume_addr", bus.instAddr_o, 32'h10);
        chk("s2_resume_pc", bus.pc_o, 32'h4);

        // 3 wait states, redirect during the 2nd wait cycle of the fetch at 0x8
        ws = 3;
        do_reset();
        for (int i = 0; i < 60 && bus.instAddr_o !== 32'h8; i++) @(negedge clk);
        chk("s3_reach8", bus.instAddr_o, 32'h8);
        @(negedge clk);
        pulse_redirect(32'h100);
        chk("s3_hold_req", 32'(bus.request_o), 32'h1);
        chk("s3_hold_addr", bus.instAddr_o, 32'h8);
        chk("s3_flushed", 32'(bus.instValid_o), 32'h0);
        for (int i = 0; i < 20 && bus.instAddr_o !== 32'h100; i++) @(negedge clk);
        chk("s3_addr100", bus.instAddr_o, 32'h100);
        for (int i = 0; i < 20 && bus.instValid_o !== 1'b1; i++) @(negedge clk);
        chk("s3_first_pc", bus.pc_o, 32'h100);

        // Redirect coinciding with dataOk
        ws = 0;
        repeat (3) @(negedge clk);
        pulse_redirect(32'h203);
        chk("s4_addr", bus.instAddr_o, 32'h200);
        chk("s4_empty", 32'(bus.instValid_o), 32'h0);
        @(negedge clk);
        chk("s4_addr_next", bus.instAddr_o, 32'h204);
        chk("s4_pc", bus.pc_o, 32'h200);
        chk("s4_inst", bus.inst_o, 32'h5A5A_0D0F);

        // Address wrap at the top of memory
        pulse_redirect(32'hFFFF_FFF8);
        for (int i = 0; i < 20 && !(bus.instValid_o === 1'b1 && bus.pc_o === 32'hFFFF_FFFC); i++)
            @(negedge clk);
        chk("s5_pc_top", bus.pc_o, 32'hFFFF_FFFC);
        chk("s5_addr_wrap", bus.instAddr_o, 32'h0);
        @(negedge clk);
        chk("s5_pc_wrap", bus.pc_o, 32'h0);
        chk("s5_addr4", bus.instAddr_o, 32'h4);

        // Reset while a transfer is outstanding
        ws = 3;
        bus.instReady_i = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20 && !(bus.request_o === 1'b1 && bus.dataOk_i === 1'b0); i++)
            @(negedge clk);
        chk("s6_pre_valid", 32'(bus.instValid_o), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("s6_req_drop", 32'(bus.request_o), 32'h0);
        chk("s6_valid_drop", 32'(bus.instValid_o), 32'h0);
        chk("s6_addr_rst", bus.instAddr_o, RESET_PC);
        @(negedge clk);
        chk("s6_restart_req", 32'(bus.request_o), 32'h1);
        chk("s6_restart_addr", bus.instAddr_o, RESET_PC);

        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
